// File: rtl/imem_pkg.sv
// Shared constants, loader state encoding and word-count clamp for the instruction-memory loader.
// Pure declarations: no latency, no flow control.
package imem_pkg;

  localparam int DEPTH          = 256;
  localparam int ADDR_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Requests larger than the memory are truncated so the write address never wraps.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] req);
    clamp_count = (req > DEPTH_CNT) ? DEPTH_CNT : req;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler; the byte lands in the word one cycle after its strobe.
// word_full_o flags the strobe carrying the last byte of a word; no flow control of its own.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        xfer_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [31:0]       word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (xfer_i) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (idx_q == BIDX_W'(k)) begin
          word_d[8*k +: 8] = byte_i;
        end
      end
      // The index wraps naturally to 0 after the last byte of a word.
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = xfer_i && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams host bytes into instruction memory as 32-bit words, holding the core in reset meanwhile.
// 5 cycles per word minimum (4 bytes + 1 write); byte_ready is low outside RECV, stalls hold the partial word.
module imem_loader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done
);

  state_e          state_q, state_d;
  logic [ADDR_W:0] n_q, n_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic            accept;
  logic            xfer;
  logic            word_full;
  logic            last_word;

  assign accept    = (state_q == ST_IDLE) && start;
  assign xfer      = byte_valid && byte_ready;
  assign last_word = ((wcnt_q + 1'b1) == n_q);

  byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (accept),
    .xfer_i      (xfer),
    .byte_i      (byte_data),
    .word_o      (mem_wdata),
    .word_full_o (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (word_count == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (word_full) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = last_word ? ST_DONE : ST_RECV;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_hold = busy;

  // The write address is the word counter itself; it only advances after the write cycle.
  always_comb begin
    n_d    = n_q;
    wcnt_d = wcnt_q;
    if (accept) begin
      n_d    = clamp_count(word_count);
      wcnt_d = '0;
    end else if (state_q == ST_WRITE) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q    <= '0;
      wcnt_q <= '0;
    end else begin
      n_q    <= n_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign mem_waddr = wcnt_q[ADDR_W-1:0];

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed steps with random byte streams and gaps against a word-level model.
module tb_imem_loader;
  import imem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, mem_we, busy, cpu_hold, done;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int viol = 0;
  logic prev_we = 1'b0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [7:0]        stream[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done)
  );

  // Record every memory write and watch cycle-level invariants.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_waddr);
      wr_data_q.push_back(mem_wdata);
    end
    if (done === 1'b1) done_cnt++;
    if (cpu_hold !== busy) viol++;
    if (mem_we && byte_ready) viol++;
    if (done && busy) viol++;
    if (mem_we && prev_we) viol++;
    prev_we = mem_we;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int w);
    @(negedge clk);
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(w);
    @(negedge clk);
    start      = 1'b0;
    word_count = (ADDR_W + 1)'($urandom);
  endtask

  task automatic make_stream(input int nbytes);
    stream.delete();
    for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
  endtask

  // Offer stream bytes with random gaps; optional forced 3-cycle stall and one stray start pulse.
  task automatic feed(input int gap_pct, input int spur_at, input int stall_at);
    int fidx = 0;
    int guard = 0;
    int stall = 0;
    bit spurred = 1'b0;
    while (fidx < stream.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      byte_valid = ($urandom_range(99) >= gap_pct);
      if (fidx == stall_at && stall < 3) begin
        byte_valid = 1'b0;
        stall++;
      end
      byte_data = byte_valid ? stream[fidx] : 8'($urandom);
      if (!spurred && fidx == spur_at) begin
        start      = 1'b1;
        word_count = (ADDR_W + 1)'(7);
        spurred    = 1'b1;
      end
      if (byte_valid && byte_ready) fidx++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    if (fidx < stream.size()) chk("feed_timeout", 64'(fidx), 64'(stream.size()));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(done), 64'd1);
    @(negedge clk);
  endtask

  // Model: word i is bytes 4i..4i+3 little-endian, written at address i, for min(w, DEPTH) words.
  task automatic check_writes(input int w, input string tag);
    int n;
    n = (w > DEPTH) ? DEPTH : w;
    chk({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      logic [31:0] exp_w;
      exp_w = 32'(stream[4*i]) | (32'(stream[4*i+1]) << 8) |
              (32'(stream[4*i+2]) << 16) | (32'(stream[4*i+3]) << 24);
      chk({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
      chk({tag, "_data"}, 64'(wr_data_q[i]), 64'(exp_w));
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  initial begin
    logic [7:0] sw[4];
    int d0;
    int w;

    // Reset held with start and byte_valid asserted.
    start = 1'b1;
    byte_valid = 1'b1;
    word_count = 9'd5;
    byte_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_idle_busy", 64'(busy), 64'd0);
    chk("rst_no_writes", 64'(wr_addr_q.size()), 64'd0);

    // Single word with no gaps, checked cycle by cycle.
    sw[0] = 8'h13; sw[1] = 8'h00; sw[2] = 8'h50; sw[3] = 8'h00;
    do_start(1);
    chk("one_ready_lat", 64'(byte_ready), 64'd1);
    chk("one_busy", 64'(busy), 64'd1);
    chk("one_cpu_hold", 64'(cpu_hold), 64'd1);
    for (int k = 0; k < 4; k++) begin
      byte_valid = 1'b1;
      byte_data  = sw[k];
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("one_we", 64'(mem_we), 64'd1);
    chk("one_waddr", 64'(mem_waddr), 64'd0);
    chk("one_wdata", 64'(mem_wdata), 64'h0050_0013);
    chk("one_ready_wr", 64'(byte_ready), 64'd0);
    chk("one_busy_wr", 64'(busy), 64'd1);
    @(negedge clk);
    chk("one_done", 64'(done), 64'd1);
    chk("one_busy_done", 64'(busy), 64'd0);
    chk("one_we_off", 64'(mem_we), 64'd0);
    @(negedge clk);
    chk("one_done_pulse", 64'(done), 64'd0);
    chk("one_nwr", 64'(wr_addr_q.size()), 64'd1);
    wr_addr_q.delete();
    wr_data_q.delete();

    // Two words 0x01..0x08, 3-cycle stall mid-word, byte_valid held high through WRITE.
    stream.delete();
    for (int i = 1; i <= 8; i++) stream.push_back(8'(i));
    do_start(2);
    feed(0, -1, 2);
    wait_done("bp_done", 50);
    check_writes(2, "bp");

    // Zero words: done right after start, no write.
    do_start(0);
    chk("zero_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_nwr", 64'(wr_addr_q.size()), 64'd0);

    // Oversized request clamps to the full memory.
    make_stream(4 * DEPTH);
    do_start(300);
    feed(15, -1, -1);
    wait_done("clamp_done", 50);
    check_writes(300, "clamp");
    repeat (3) @(negedge clk);
    chk("clamp_idle", 64'(busy), 64'd0);

    // Stray start during the second word of a 3-word load.
    @(posedge clk);
    d0 = done_cnt;
    make_stream(12);
    do_start(3);
    feed(20, 6, -1);
    wait_done("spur_done", 50);
    check_writes(3, "spur");
    repeat (10) @(negedge clk);
    chk("spur_idle", 64'(busy), 64'd0);
    @(posedge clk);
    chk("spur_one_done", 64'(done_cnt - d0), 64'd1);

    // Reset after word 0 and 2 bytes of word 1.
    d0 = done_cnt;
    make_stream(6);
    do_start(3);
    feed(0, -1, -1);
    rst_n = 1'b0;
    byte_valid = 1'b1;
    byte_data = 8'h5A;
    repeat (2) @(negedge clk);
    chk("mid_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("mid_we", 64'(mem_we), 64'd0);
    rst_n = 1'b1;
    byte_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_still_idle", 64'(cpu_hold), 64'd0);
    check_writes(1, "mid");
    @(posedge clk);
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);
    make_stream(4);
    do_start(1);
    feed(30, -1, -1);
    wait_done("reload_done", 50);
    check_writes(1, "reload");

    // Random short loads with random gaps.
    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(1, 6);
      make_stream(4 * w);
      do_start(w);
      feed($urandom_range(0, 60), -1, -1);
      wait_done("rnd_done", 50);
      check_writes(w, "rnd");
    end

    @(posedge clk);
    chk("total_done", 64'(done_cnt), 64'd10);
    chk("protocol", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the 256 x 32-bit instruction memory: accepts a byte stream from a host/boot link and writes it into instruction memory as 32-bit words.
- Assembles little-endian words, drives a one-cycle write strobe with a word address, and holds the CPU core in reset while loading.
- Sits between the boot/debug byte source and the instruction memory write port; the fetch-side read path is unaffected.

Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory.
- ADDR_W, 8, word-address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; sampled on an accepted start.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_waddr  out  ADDR_W  word address; byte address = mem_waddr << 2.
- mem_wdata  out  32  assembled instruction word.
- busy  out  1  load in progress (RECV or WRITE).
- cpu_hold  out  1  equals busy; holds the core's PC/pipeline in reset.
- done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. byte_ready, mem_we, busy, cpu_hold and done are 0. mem_waddr, mem_wdata, the byte counter and the word counter are 0. Already-written memory contents are not cleared.
- All outputs are registered or decoded from state only; nothing combinational from inputs to outputs.
- A byte transfer happens on a clk edge where byte_valid && byte_ready; no other byte is consumed. byte_data may change freely when not transferred.
- States:
  - IDLE: byte_ready=0. On start, latch N = min(word_count, DEPTH) and clear both counters.
    - N=0 -> DONE.
    - N>0 -> RECV.
  - RECV: byte_ready=1, busy=1. Byte k of the current word (k=0..3) lands in mem_wdata[8k+7:8k] (little-endian). On the 4th transfer -> WRITE.
  - WRITE: byte_ready=0, mem_we=1 for exactly this cycle. mem_waddr = word counter; mem_wdata is stable. Then increment the word counter.
    - Counter reaches N -> DONE.
    - Otherwise -> RECV.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 write cycle). Latency from start to first byte_ready=1 is 1 cycle.
- start while not in IDLE is ignored; word_count is only sampled on an accepted start.
- word_count > DEPTH clamps to DEPTH. mem_waddr never wraps past DEPTH-1 within one load.
- byte_valid stalls (low) in RECV: hold state and the partial word indefinitely.
- Reset mid-load: return to IDLE immediately. cpu_hold drops, no done pulse, and the partial word is discarded (no write).
- Simultaneous start and rst_n=0: reset wins.

Decomposition:
- Shared package/header imem_pkg: DEPTH, ADDR_W, loader state encoding (IDLE, RECV, WRITE, DONE), BYTES_PER_WORD=4.
- One sub-module: byte_packer. It holds a 2-bit byte index and a 32-bit shift/insert register, takes a transfer strobe and byte, and outputs the word plus a word_full flag. The FSM and counters stay in imem_loader.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving start=1 and byte_valid=1 -> all outputs 0, state IDLE, no mem_we.
- Single word: start with word_count=1, then bytes 0x13,0x00,0x50,0x00 with no gaps -> one mem_we with mem_waddr=0 and mem_wdata=0x00500013 on the cycle after the 4th byte, done the next cycle, busy/cpu_hold high between start+1 and the write cycle.
- Back-pressure and gaps: word_count=2, 8 bytes 0x01..0x08 with byte_valid deasserted for 3 cycles mid-word -> writes 0x04030201 at addr 0 and 0x08070605 at addr 1. byte_ready is 0 in each WRITE cycle, and no byte is dropped or duplicated.
- Zero and clamp: word_count=0 -> done one cycle after start, no write. word_count=300 -> exactly 256 writes to addresses 0..255, then done.
- Start while busy: second start pulse during the 2nd word of a 3-word load -> ignored; exactly 3 writes and one done.
- Reset mid-load: assert rst_n=0 after 2 bytes of word 1 (word 0 already written) -> no further mem_we, no done, cpu_hold=0. A new load of 1 word afterwards writes addr 0 correctly.
